// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage hazard request and pipeline control bundle
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr;
    logic              id_rs1_used;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_rd_wren;
    logic              id_is_load;
    logic              br_taken;
    logic              mem_busy;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              flush_if;
    logic              stall_all;
    logic [PC_W-1:0]   stall_cycles;

    modport master (
        output id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
        output id_rd_addr, id_rd_wren, id_is_load, br_taken, mem_busy,
        input  stall_if, stall_id, bubble_ex, flush_if, stall_all, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
        input  id_rd_addr, id_rd_wren, id_is_load, br_taken, mem_busy,
        output stall_if, stall_id, bubble_ex, flush_if, stall_all, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Countdown-scoreboard RAW hazard, branch flush and freeze control
module hazard_scoreboard #(
    parameter int REG_AW    = 5,
    parameter int FWD_EN    = 1,
    parameter int LD_LAT    = 1,
    parameter int WB_LAT    = 3,
    parameter int FLUSH_CYC = 2,
    parameter int PC_W      = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave hz
);
    localparam int         NREG         = 2 ** REG_AW;
    localparam logic [3:0] LD_CNT       = 4'(LD_LAT);
    localparam logic [3:0] WB_CNT       = 4'(WB_LAT);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYC - 1);
    localparam logic       TRACK_ALU    = (FWD_EN == 0);

    logic [NREG-1:0] pending;
    logic [3:0]      flush_cnt;
    logic [PC_W-1:0] stall_cnt;
    logic            raw;
    logic            issue;
    logic            track;
    logic            flushing;
    logic            raw_stall;

    // Hazard check sees pre-issue counters, so an instruction never waits on its own rd.
    assign raw = hz.id_valid & ((hz.id_rs1_used & pending[hz.id_rs1_addr]) |
                                (hz.id_rs2_used & pending[hz.id_rs2_addr]));
    assign issue     = hz.id_valid & ~raw & ~hz.mem_busy & ~hz.br_taken;
    assign track     = issue & hz.id_rd_wren & (hz.id_is_load | TRACK_ALU);
    assign flushing  = (flush_cnt != 4'd0);
    assign raw_stall = raw & ~hz.mem_busy & ~hz.br_taken & ~flushing;

    assign pending[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic [3:0] cnt;

        // A fresh write to this register replaces whatever countdown was running.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= 4'd0;
            end else if (track && (hz.id_rd_addr == REG_AW'(r))) begin
                cnt <= hz.id_is_load ? LD_CNT : WB_CNT;
            end else if (!hz.mem_busy && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end

        assign pending[r] = (cnt != 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 4'd0;
        end else if (!hz.mem_busy) begin
            if (hz.br_taken) begin
                flush_cnt <= FLUSH_RELOAD;
            end else if (flushing) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (raw_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PC_W'(1);
        end
    end

    always_comb begin
        hz.stall_if  = 1'b0;
        hz.stall_id  = 1'b0;
        hz.bubble_ex = 1'b0;
        hz.flush_if  = 1'b0;
        hz.stall_all = hz.mem_busy;
        if (hz.mem_busy) begin
            hz.stall_if = 1'b1;
            hz.stall_id = 1'b1;
        end else if (hz.br_taken) begin
            hz.flush_if  = 1'b1;
            hz.bubble_ex = 1'b1;
        end else if (flushing) begin
            hz.flush_if = 1'b1;
        end else if (raw) begin
            hz.stall_if  = 1'b1;
            hz.stall_id  = 1'b1;
            hz.bubble_ex = 1'b1;
        end
    end

    assign hz.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - Bench for hazard_scoreboard in three parameterisations
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5), .PC_W(32)) ia ();
    hazard_scoreboard_if #(.REG_AW(5), .PC_W(4))  ib ();
    hazard_scoreboard_if #(.REG_AW(5), .PC_W(32)) ic ();

    hazard_scoreboard dut_a (.clk(clk), .rst(rst), .hz(ia));
    hazard_scoreboard #(.FWD_EN(1), .LD_LAT(3), .WB_LAT(3), .FLUSH_CYC(3), .PC_W(4))
        dut_b (.clk(clk), .rst(rst), .hz(ib));
    hazard_scoreboard #(.FWD_EN(0), .LD_LAT(2), .WB_LAT(3), .FLUSH_CYC(2), .PC_W(32))
        dut_c (.clk(clk), .rst(rst), .hz(ic));

    logic       s_valid, s_u1, s_u2, s_wren, s_ld, s_br, s_busy;
    logic [4:0] s_rs1, s_rs2, s_rd;

    // Model time advances only on unfrozen clocks; a register is pending while time < ready.
    int     p_fwd [3] = '{1, 1, 0};
    int     p_ld  [3] = '{1, 3, 2};
    int     p_wb  [3] = '{3, 3, 3};
    int     p_fc  [3] = '{2, 3, 2};
    longint p_max [3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
    int     m_t     [3];
    int     m_ready [3][32];
    int     m_fend  [3];
    longint m_sc    [3];
    int     n_assert = 0;
    int     n_fail   = 0;

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_t[d] = 0;
            m_fend[d] = 0;
            m_sc[d] = 0;
            for (int r = 0; r < 32; r++) m_ready[d][r] = 0;
        end
    endtask

    function automatic bit model_raw(int d);
        return s_valid && ((s_u1 && s_rs1 != 0 && m_t[d] < m_ready[d][s_rs1]) ||
                           (s_u2 && s_rs2 != 0 && m_t[d] < m_ready[d][s_rs2]));
    endfunction

    task automatic model_update();
        bit raw, flushing;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_t[d] = 0;
                m_fend[d] = 0;
                m_sc[d] = 0;
                for (int r = 0; r < 32; r++) m_ready[d][r] = 0;
            end else if (!s_busy) begin
                raw = model_raw(d);
                flushing = m_t[d] < m_fend[d];
                if (s_valid && !raw && !s_br && s_wren && s_rd != 0 && (s_ld || p_fwd[d] == 0))
                    m_ready[d][s_rd] = m_t[d] + 1 + (s_ld ? p_ld[d] : p_wb[d]);
                if (s_br) m_fend[d] = m_t[d] + p_fc[d];
                else if (raw && !flushing && m_sc[d] < p_max[d]) m_sc[d]++;
                m_t[d]++;
            end
        end
    endtask

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic sif, input logic sid, input logic bub,
                             input logic fl, input logic sall, input logic [31:0] sc);
        bit   raw, flushing;
        logic e_stall, e_bub, e_fl;
        raw = model_raw(d);
        flushing = m_t[d] < m_fend[d];
        e_stall = 1'b0; e_bub = 1'b0; e_fl = 1'b0;
        if (s_busy) e_stall = 1'b1;
        else if (s_br) begin e_fl = 1'b1; e_bub = 1'b1; end
        else if (flushing) e_fl = 1'b1;
        else if (raw) begin e_stall = 1'b1; e_bub = 1'b1; end
        chk("stall_if", d, 32'(sif), 32'(e_stall));
        chk("stall_id", d, 32'(sid), 32'(e_stall));
        chk("bubble_ex", d, 32'(bub), 32'(e_bub));
        chk("flush_if", d, 32'(fl), 32'(e_fl));
        chk("stall_all", d, 32'(sall), 32'(s_busy));
        chk("stall_cycles", d, sc, 32'(m_sc[d]));
    endtask

    task automatic drive();
        ia.id_valid = s_valid; ia.id_rs1_addr = s_rs1; ia.id_rs1_used = s_u1; ia.id_rs2_addr = s_rs2;
        ia.id_rs2_used = s_u2; ia.id_rd_addr = s_rd; ia.id_rd_wren = s_wren; ia.id_is_load = s_ld;
        ia.br_taken = s_br; ia.mem_busy = s_busy;
        ib.id_valid = s_valid; ib.id_rs1_addr = s_rs1; ib.id_rs1_used = s_u1; ib.id_rs2_addr = s_rs2;
        ib.id_rs2_used = s_u2; ib.id_rd_addr = s_rd; ib.id_rd_wren = s_wren; ib.id_is_load = s_ld;
        ib.br_taken = s_br; ib.mem_busy = s_busy;
        ic.id_valid = s_valid; ic.id_rs1_addr = s_rs1; ic.id_rs1_used = s_u1; ic.id_rs2_addr = s_rs2;
        ic.id_rs2_used = s_u2; ic.id_rd_addr = s_rd; ic.id_rd_wren = s_wren; ic.id_is_load = s_ld;
        ic.br_taken = s_br; ic.mem_busy = s_busy;
    endtask

    // Called just after a rising edge: drive, check at the falling edge, then advance.
    task automatic step();
        drive();
        #4;
        check_dut(0, ia.stall_if, ia.stall_id, ia.bubble_ex, ia.flush_if, ia.stall_all, 32'(ia.stall_cycles));
        check_dut(1, ib.stall_if, ib.stall_id, ib.bubble_ex, ib.flush_if, ib.stall_all, 32'(ib.stall_cycles));
        check_dut(2, ic.stall_if, ic.stall_id, ic.bubble_ex, ic.flush_if, ic.stall_all, 32'(ic.stall_cycles));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic ins(input logic v, input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                       input logic u2, input logic [4:0] d, input logic w, input logic l);
        s_valid = v; s_rs1 = a1; s_u1 = u1; s_rs2 = a2; s_u2 = u2;
        s_rd = d; s_wren = w; s_ld = l; s_br = 1'b0; s_busy = 1'b0;
    endtask

    task automatic idle();
        ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_sc(input string tag, input int a, input int b, input int c);
        chk(tag, 0, 32'(ia.stall_cycles), 32'(a));
        chk(tag, 1, 32'(ib.stall_cycles), 32'(b));
        chk(tag, 2, 32'(ic.stall_cycles), 32'(c));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        repeat (2) step();
        rst = 1'b0;
        chk_sc("reset_sc", 0, 0, 0);

        // Load x5 then a dependent add.
        ins(1, 0, 0, 0, 0, 5, 1, 1); step();
        ins(1, 5, 1, 7, 1, 6, 1, 0); repeat (4) step();
        idle(); repeat (4) step();
        chk_sc("load_use_sc", 1, 3, 2);

        // x0 is never pending.
        ins(1, 0, 0, 0, 0, 0, 1, 1); step();
        ins(1, 0, 1, 0, 1, 1, 1, 0); step();

        // ALU writer then dependent: only the no-forwarding instance tracks it.
        ins(1, 0, 0, 0, 0, 3, 1, 0); step();
        ins(1, 3, 1, 0, 0, 4, 1, 0); repeat (4) step();
        idle(); repeat (3) step();
        chk_sc("wb_lat_sc", 1, 3, 5);

        // Taken branch over a pending load; the concurrent RAW is not counted.
        ins(1, 0, 0, 0, 0, 5, 1, 1); step();
        ins(1, 5, 1, 0, 0, 6, 1, 0); s_br = 1'b1; step();
        s_br = 1'b0; repeat (4) step();
        idle(); repeat (3) step();
        chk_sc("branch_sc", 1, 3, 5);

        // Memory freeze holds the scoreboard.
        ins(1, 0, 0, 0, 0, 5, 1, 1); step();
        ins(1, 5, 1, 0, 0, 6, 1, 0); s_busy = 1'b1; repeat (4) step();
        s_busy = 1'b0; repeat (4) step();
        idle(); repeat (3) step();
        chk_sc("freeze_sc", 2, 6, 7);

        // Back-to-back writers to x8: non-load does not retrack, load does.
        ins(1, 0, 0, 0, 0, 8, 1, 1); step();
        idle(); step();
        ins(1, 0, 0, 0, 0, 8, 1, 0); step();
        ins(1, 8, 1, 0, 0, 9, 1, 0); repeat (3) step();
        idle(); repeat (3) step();
        chk_sc("b2b_alu_sc", 2, 7, 10);
        ins(1, 0, 0, 0, 0, 8, 1, 1); step();
        idle(); step();
        ins(1, 0, 0, 0, 0, 8, 1, 1); step();
        ins(1, 8, 1, 0, 0, 9, 1, 0); repeat (4) step();
        idle(); repeat (4) step();
        chk_sc("b2b_load_sc", 3, 10, 12);

        // Reset while x9 is pending and the flush counter is running.
        ins(1, 0, 0, 0, 0, 9, 1, 1); step();
        idle(); s_br = 1'b1; step();
        ins(1, 9, 1, 0, 0, 10, 1, 0);
        drive();
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_flush_if", 1, 32'(ib.flush_if), 32'd0);
        chk("rst_stall_id", 1, 32'(ib.stall_id), 32'd0);
        step();
        rst = 1'b0;
        repeat (2) step();
        chk_sc("post_reset_sc", 0, 0, 0);

        // Self-dependent load chain drives the 4-bit counter into saturation.
        ins(1, 10, 1, 0, 0, 10, 1, 1); repeat (40) step();
        idle(); step();
        chk("sat_sc", 1, 32'(ib.stall_cycles), 32'd15);

        // Random traffic on a small register window.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                rst = 1'b1;
                model_reset();
            end
            s_valid = ($urandom_range(9) < 8);
            s_rs1 = 5'($urandom_range(7)); s_u1 = 1'($urandom_range(1));
            s_rs2 = 5'($urandom_range(7)); s_u2 = 1'($urandom_range(1));
            s_rd = 5'($urandom_range(7)); s_wren = 1'($urandom_range(1));
            s_ld = 1'($urandom_range(1));
            s_br = ($urandom_range(9) == 0);
            s_busy = ($urandom_range(9) == 0);
            step();
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational hazard unit.
- Tracks in-flight register writes in a per-register countdown scoreboard, so stall length follows the configured load/writeback latency rather than fixed pipeline-stage comparisons.
- Adds a multi-cycle front-end flush after a taken branch, a global memory-busy freeze, and a saturating stall-cycle performance counter.
- Sits beside the ID stage; drives stall/flush controls to the IF/ID, ID/EX and later pipeline registers.

Parameters:
- REG_AW, 5, register address width; scoreboard has 2**REG_AW entries, entry 0 never tracked.
- FWD_EN, 1, 1 = forwarding present, only loads tracked; 0 = every register write tracked.
- LD_LAT, 1, cycles a consumer in ID must wait after a load leaves ID (1..15).
- WB_LAT, 3, cycles a consumer must wait after a non-load write leaves ID, used only when FWD_EN=0 (1..15).
- FLUSH_CYC, 2, cycles flush_if stays asserted after a taken branch (1..15).
- PC_W, 32, width of stall_cycles counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_addr  in  REG_AW  ID source 1.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_addr  in  REG_AW  ID source 2.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd_addr  in  REG_AW  ID destination.
- id_rd_wren  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- br_taken  in  1  branch/jump in EX redirects the PC this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline freezes.
- stall_if  out  1  hold PC and the IF/ID register.
- stall_id  out  1  hold the ID instruction.
- bubble_ex  out  1  insert a NOP into ID/EX.
- flush_if  out  1  kill the IF/ID register contents.
- stall_all  out  1  freeze every pipeline register (equals mem_busy).
- stall_cycles  out  PC_W  saturating count of RAW stall cycles.

Behaviour:
- Reset (async, rst=1): all scoreboard counters = 0, flush counter = 0, stall_cycles = 0. Control outputs then follow only the inputs (stall_all=mem_busy, flush_if=br_taken & ~mem_busy).
- Scoreboard: cnt[r] is a 4-bit counter for each r in 1..2**REG_AW-1. cnt[r] != 0 means r is pending.
- RAW hazard (combinational): raw = id_valid & ((id_rs1_used & rs1!=0 & cnt[rs1]!=0) | (id_rs2_used & rs2!=0 & cnt[rs2]!=0)).
- Issue: issue = id_valid & ~raw & ~mem_busy & ~br_taken.
  - On issue, if id_rd_wren & rd!=0 & (id_is_load | ~FWD_EN): cnt[rd] <= id_is_load ? LD_LAT : WB_LAT.
  - This overrides the decrement of the same entry in that cycle; the younger writer wins.
- Decrement: each clock with mem_busy=0, every nonzero counter not being loaded decrements by 1. While mem_busy=1, all counters hold.
- Output priority, highest first:
  1. mem_busy=1: stall_all=1, stall_if=1, stall_id=1; bubble_ex=0, flush_if=0. Upstream holds br_taken until the freeze releases.
  2. br_taken=1: flush_if=1, bubble_ex=1 (kills the ID instruction), stall_if=0, stall_id=0. The flush counter loads FLUSH_CYC-1.
  3. Flush counter nonzero: flush_if=1, counter decrements each unfrozen cycle, no other effect. A new br_taken reloads the counter.
  4. raw=1: stall_if=1, stall_id=1, bubble_ex=1; stall_cycles += 1, saturating at all-ones.
  5. Otherwise all outputs 0.
- Boundaries:
  - rs==rd of the issuing instruction does not self-stall, because the check uses pre-issue counters.
  - x0 is never pending.
  - Reset asserted mid-stall clears all pending state immediately.
  - br_taken coincident with raw: the flush wins and no stall is counted.
- Latency: zero-cycle (combinational) decisions; scoreboard and counters update on the clock edge.

Test Plan:
- Load-use, LD_LAT=1, FWD_EN=1: load x5 issues at cycle 0; add x6,x5,x7 in ID at cycle 1 → stall_id=1 and bubble_ex=1 at cycle 1 only; issues at cycle 2; stall_cycles=1.
- FWD_EN=0, WB_LAT=3: addi x3 issues, dependent follows → stall_id=1 for exactly 3 cycles; stall_cycles=3. A dependent on x0 → no stall.
- Taken branch with FLUSH_CYC=2: br_taken at cycle 4 → flush_if=1 at cycles 4–5, bubble_ex=1 at cycle 4 only; a concurrent RAW condition does not increment stall_cycles.
- mem_busy held 4 cycles while cnt[x5]=1 → stall_all=1 for those 4 cycles, cnt[x5] stays 1; after release a dependent stalls exactly 1 more cycle.
- Back-to-back writers: load x8 (LD_LAT=3), then non-load x8 issues two cycles later with FWD_EN=1 → the second issue does not retrack x8, so the dependent stalls 1 remaining cycle; a load in that slot reloads cnt[x8]=3 instead.
- Assert rst while cnt[x9]=2 and the flush counter is nonzero → all counters 0 and flush_if=0 immediately; the next dependent on x9 does not stall.
